// File: rtl/regfile_sb.sv
// Multi-port register file with pending-write scoreboard; r0 reads zero and is never busy.
// Optional write-to-read forwarding when REGFILE_SB_BYPASS_EN is defined.
module regfile_sb #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned NUM_RD = 4,
  parameter int unsigned NUM_WR = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR-1:0]        iss_en,
  input  logic [NUM_WR*ADDR_W-1:0] iss_addr
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_busy;

  // Later non-blocking assignments override earlier ones: higher write port wins,
  // and the set loop follows the clear loop so issue beats writeback.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
          r_regs[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
          r_busy[wr_addr[j*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (iss_en[j] && (iss_addr[j*ADDR_W +: ADDR_W] != '0))
          r_busy[iss_addr[j*ADDR_W +: ADDR_W]] <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      if (rd_addr[k*ADDR_W +: ADDR_W] != '0) begin
        rd_data[k*DATA_W +: DATA_W] = r_regs[rd_addr[k*ADDR_W +: ADDR_W]];
        rd_busy[k]                  = r_busy[rd_addr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_SB_BYPASS_EN
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr[k*ADDR_W +: ADDR_W])) begin
            rd_data[k*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
            rd_busy[k]                  = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed cases plus randomized traffic against an array model.
module tb_regfile_sb;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 4;
  localparam int NW = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NR*AW-1:0]  rd_addr = '0;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic [NW-1:0]     wr_en = '0;
  logic [NW*AW-1:0]  wr_addr = '0;
  logic [NW*DW-1:0]  wr_data = '0;
  logic [NW-1:0]     iss_en = '0;
  logic [NW*AW-1:0]  iss_addr = '0;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_regs [8];
  bit          m_busy [8];
  bit          mvalid = 1'b0;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr)
  );

  always #5 clock = ~clock;

  // Architectural model: state changes at the edge from the inputs held during the cycle.
  always @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < 8; r++) begin m_regs[r] = 16'h0; m_busy[r] = 1'b0; end
      mvalid = 1'b1;
    end else begin
      bit set_r, clr_r;
      for (int j = 0; j < NW; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] != 0) m_regs[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
      for (int r = 1; r < 8; r++) begin
        set_r = 1'b0; clr_r = 1'b0;
        for (int j = 0; j < NW; j++) begin
          if (iss_en[j] && iss_addr[j*AW +: AW] == r) set_r = 1'b1;
          if (wr_en[j] && wr_addr[j*AW +: AW] == r)   clr_r = 1'b1;
        end
        m_busy[r] = set_r ? 1'b1 : (clr_r ? 1'b0 : m_busy[r]);
      end
    end
  end

  function automatic logic [16:0] expect_rd(input int a);
    logic [15:0] d;
    logic        b;
    d = (a == 0) ? 16'h0 : m_regs[a];
    b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_SB_BYPASS_EN
    for (int j = 0; j < NW; j++)
      if (a != 0 && wr_en[j] && wr_addr[j*AW +: AW] == a) begin d = wr_data[j*DW +: DW]; b = 1'b0; end
`endif
    return {b, d};
  endfunction

  task automatic chk(input string name, input int port, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s port %0d addr %0d got %h expected %h", name, port, rd_addr[port*AW +: AW], act, exp);
    end
  endtask

  // Continuous comparison against the model at every falling edge.
  always @(negedge clock) begin
    if (mvalid) begin
      for (int k = 0; k < NR; k++) begin
        logic [16:0] e;
        e = expect_rd(int'(rd_addr[k*AW +: AW]));
        chk("model_data", k, rd_data[k*DW +: DW], e[15:0]);
        chk("model_busy", k, {15'h0, rd_busy[k]}, {15'h0, e[16]});
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic read_all(input int a);
    for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = AW'(a);
    #2;
  endtask

  task automatic lit(input string name, input logic [15:0] d, input logic b);
    for (int k = 0; k < NR; k++) begin
      chk({name, "_data"}, k, rd_data[k*DW +: DW], d);
      chk({name, "_busy"}, k, {15'h0, rd_busy[k]}, {15'h0, b});
    end
  endtask

  task automatic set_wr(input int j, input logic en, input int a, input logic [15:0] d);
    wr_en[j] = en; wr_addr[j*AW +: AW] = AW'(a); wr_data[j*DW +: DW] = d;
  endtask

  task automatic set_iss(input int j, input logic en, input int a);
    iss_en[j] = en; iss_addr[j*AW +: AW] = AW'(a);
  endtask

  task automatic idle();
    wr_en = '0; iss_en = '0;
  endtask

  initial begin
    #1;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin read_all(a); lit("reset", 16'h0000, 1'b0); end

    set_wr(0, 1'b1, 3, 16'hABCD);
    cyc(); idle();
    read_all(3); lit("wr_r3", 16'hABCD, 1'b0);
    set_wr(0, 1'b1, 0, 16'h1234);
    cyc(); idle();
    read_all(0); lit("wr_r0", 16'h0000, 1'b0);

    set_wr(0, 1'b1, 5, 16'h1111); set_wr(1, 1'b1, 5, 16'h2222);
    cyc(); idle();
    read_all(5); lit("conflict", 16'h2222, 1'b0);

    set_iss(0, 1'b1, 2);
    cyc(); idle();
    read_all(2); lit("issue", 16'h0000, 1'b1);
    set_wr(1, 1'b1, 2, 16'h00FF);
    cyc(); idle();
    read_all(2); lit("wb", 16'h00FF, 1'b0);
    set_iss(1, 1'b1, 2); set_wr(0, 1'b1, 2, 16'h0ABC);
    cyc(); idle();
    read_all(2); lit("iss_wins", 16'h0ABC, 1'b1);

    set_wr(0, 1'b1, 4, 16'h5A5A);
    read_all(4);
`ifdef REGFILE_SB_BYPASS_EN
    lit("bypass_same", 16'h5A5A, 1'b0);
`else
    lit("nobypass_same", 16'h0000, 1'b0);
`endif
    cyc(); idle();
    read_all(4); lit("bypass_next", 16'h5A5A, 1'b0);

    set_wr(0, 1'b1, 1, 16'h7777); set_iss(0, 1'b1, 6);
    cyc(); idle();
    read_all(1); lit("pre_rst_r1", 16'h7777, 1'b0);
    read_all(6); lit("pre_rst_r6", 16'h0000, 1'b1);
    reset = 1'b1; set_wr(1, 1'b1, 1, 16'h1111); set_iss(1, 1'b1, 3);
    cyc(); reset = 1'b0; idle();
    for (int a = 0; a < 8; a++) begin read_all(a); lit("mid_reset", 16'h0000, 1'b0); end

    for (int n = 0; n < 3000; n++) begin
      for (int j = 0; j < NW; j++) begin
        set_wr(j, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 16'($urandom));
        set_iss(j, 1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)));
      end
      for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
      reset = ($urandom_range(0, 99) == 0);
      cyc();
    end
    reset = 1'b0; idle();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
